core_alloc_rr: RTL
==================

Name: core_alloc_rr

Overview:
- Sequential round-robin core allocator for the DSP/GPU task dispatcher.
- Holds a busy/free state per core and accepts task requests through a valid/ready handshake.
- Grants the next free, enabled core after the last-granted one, with wrap-around, and frees cores on per-core done pulses.
- Adds a drain/halt state machine so the control unit can stop dispatch and wait for all cores to go idle.

Parameters:
- NUM_CORES, 16, number of cores managed (≥2).
- ID_W, $clog2(NUM_CORES), width of a core id.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- core_enable  in  NUM_CORES  per-core eligibility mask; 0 excludes the core from search.
- core_done  in  NUM_CORES  one-cycle per-core completion pulses.
- flush  in  1  returns every core to free.
- halt_req  in  1  level; requests drain and halt of dispatch.
- req_valid  in  1  task request.
- req_ready  out  1  allocator can grant this cycle.
- grant_valid  out  1  one-cycle grant strobe.
- grant_id  out  ID_W  granted core id.
- busy_mask  out  NUM_CORES  registered busy state.
- halted  out  1  FSM in HALTED.
- err_done_free  out  1  sticky flag: done pulse seen for a core that is not busy.

Behaviour:
Reset values:
- busy_mask=0, grant_valid=0, grant_id=0, halted=0, err_done_free=0.
- Pointer ptr=NUM_CORES-1, so the first grant goes to the lowest eligible id. FSM=RUN.

Candidate search (combinational from registered state):
- Eligible set is cand = ~busy_mask & core_enable.
- Search order is ptr+1, ptr+2, … modulo NUM_CORES, NUM_CORES positions. The first set bit wins.
- Index arithmetic is done in ID_W+1 bits, then wrapped by subtracting NUM_CORES. NUM_CORES need not be a power of 2.
- req_ready = (FSM==RUN) && (cand!=0). It must not depend on req_valid.

Handshake:
- A grant happens when req_valid && req_ready at an edge.
- Next cycle: grant_valid=1, grant_id=winner, busy_mask[winner]=1, ptr=winner. Latency is 1 cycle.
- grant_valid is 0 in every cycle without a grant. grant_id holds its last value.
- At most one grant per cycle.

Release:
- core_done[i] with busy_mask[i]=1 clears the bit at that edge. The effect is visible from the next cycle; there is no same-cycle bypass into cand.
- core_done[i] with busy_mask[i]=0 is ignored for state and sets err_done_free. The flag is cleared only by reset.

Simultaneous events:
- A grant to core i plus core_done[j] in the same cycle: both applied.
- A done for the core being granted cannot match a busy bit. It sets err_done_free and the grant still sets the bit.

flush:
- Next state busy_mask=0. ptr and err are kept.
- flush has priority over a same-cycle grant: the grant strobe still fires, but the busy bit ends at 0.

Disabling a core:
- Deasserting core_enable[i] while the core is busy does not free it. The core only stops being a candidate.

FSM:
- RUN → DRAIN when halt_req=1. req_ready is 0 from the cycle the FSM is in DRAIN.
- DRAIN → HALTED when busy_mask==0 (evaluated on registered state). DRAIN → RUN if halt_req drops first.
- HALTED → RUN when halt_req=0.
- halted=1 only in HALTED (registered, same edge as the state).
- A halt_req rising in the same cycle as a grant handshake lets that grant complete.

All-busy or all-disabled:
- req_ready=0. ptr is unchanged.

Optional Feature:
- Macro: CORE_ALLOC_STATS_EN.
- When defined, adds outputs busy_count (ID_W+1 bits, popcount of busy_mask, registered, reset 0) and grant_count (32-bit count of grants, wraps at 2^32, reset 0, cleared by flush).
- When undefined, the ports and logic are absent. All other behaviour is identical.

Test Plan:
- NUM_CORES=4, enable=4'b1111, req_valid held 5 cycles → grants 0,1,2,3 on successive cycles; req_ready=0 in the 5th cycle; busy_mask=4'b1111.
- From all busy, core_done[2] pulse, then req_valid → grant_id=2 one cycle after the handshake, not before.
- enable=4'b1010, ptr=3 (last grant was 3), cores 1 and 3 free → next grant id 1, then 3 (wrap checked).
- NUM_CORES=5, busy=5'b01111, ptr=3 → grant_id=4. After freeing core 0 → next grant_id=0.
- Cores 0 and 1 busy, halt_req=1 → req_ready=0 immediately. Done pulses for 0 and 1 → halted=1 on the cycle after busy_mask reaches 0. halt_req=0 → halted=0 and req_ready=1.
- core_done[3] while core 3 is free → err_done_free=1 and stays 1. flush with busy=4'b0110 → busy_mask=0 next cycle.

Source files
------------

// File: rtl/core_alloc_rr.sv
// Round-robin core allocator with a valid/ready grant handshake, per-core done release and a run/drain/halt FSM.
// Optional busy_count/grant_count statistics outputs are built when CORE_ALLOC_STATS_EN is defined.
module core_alloc_rr #(
    parameter int NUM_CORES = 16,
    parameter int ID_W      = $clog2(NUM_CORES)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CORES-1:0] core_enable,
    input  logic [NUM_CORES-1:0] core_done,
    input  logic                 flush,
    input  logic                 halt_req,
    input  logic                 req_valid,
    output logic                 req_ready,
    output logic                 grant_valid,
    output logic [ID_W-1:0]      grant_id,
    output logic [NUM_CORES-1:0] busy_mask,
    output logic                 halted,
    output logic                 err_done_free
`ifdef CORE_ALLOC_STATS_EN
    ,
    output logic [ID_W:0]        busy_count,
    output logic [31:0]          grant_count
`endif
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t               state;
    logic [ID_W-1:0]      ptr;
    logic [ID_W-1:0]      winner;
    logic [ID_W:0]        idx;
    logic [NUM_CORES-1:0] cand;
    logic [NUM_CORES-1:0] busy_next;
    logic                 found;
    logic                 grant;

    // Scan NUM_CORES positions starting just after the last grant; the extra bit lets the sum exceed NUM_CORES before wrapping.
    always_comb begin
        cand   = ~busy_mask & core_enable;
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            idx = {1'b0, ptr} + (ID_W+1)'(k);
            if (idx >= (ID_W+1)'(NUM_CORES))
                idx = idx - (ID_W+1)'(NUM_CORES);
            if (!found && cand[idx[ID_W-1:0]]) begin
                found  = 1'b1;
                winner = idx[ID_W-1:0];
            end
        end
    end

    assign req_ready = (state == RUN) && (cand != '0);
    assign grant     = req_valid && req_ready;

    // Release first, then the grant sets its bit, and flush overrides everything.
    always_comb begin
        busy_next = busy_mask & ~core_done;
        if (grant)
            busy_next[winner] = 1'b1;
        if (flush)
            busy_next = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_mask     <= '0;
            ptr           <= ID_W'(NUM_CORES - 1);
            state         <= RUN;
            grant_valid   <= 1'b0;
            grant_id      <= '0;
            halted        <= 1'b0;
            err_done_free <= 1'b0;
        end else begin
            busy_mask   <= busy_next;
            grant_valid <= grant;
            if (grant) begin
                grant_id <= winner;
                ptr      <= winner;
            end
            if ((core_done & ~busy_mask) != '0)
                err_done_free <= 1'b1;
            case (state)
                RUN: begin
                    if (halt_req)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (!halt_req) begin
                        state <= RUN;
                    end else if (busy_mask == '0) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    if (!halt_req) begin
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

`ifdef CORE_ALLOC_STATS_EN
    logic [ID_W:0] pop_next;

    // Counting the next busy state keeps busy_count aligned with busy_mask in the same cycle.
    always_comb begin
        pop_next = '0;
        for (int i = 0; i < NUM_CORES; i++)
            pop_next = pop_next + (ID_W+1)'(busy_next[i]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_count  <= '0;
            grant_count <= '0;
        end else begin
            busy_count <= pop_next;
            if (flush)
                grant_count <= '0;
            else if (grant)
                grant_count <= grant_count + 32'd1;
        end
    end
`endif

endmodule
